// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: ALUOp codes, default width and
// response-register state encoding.
package alu_arb_pkg;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_OR   = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;
   localparam logic [1:0] ALU_NAND = 2'b11;

   localparam int WIDTH_DEF = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/ALU/response bundle between requesters, the arbiter and the
// shared ALU. slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arbiter_if #(
   parameter int NREQ  = 2,
   parameter int WIDTH = 32
) ();
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*2-1:0]     req_op;
   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic [1:0]            alu_op;
   logic [WIDTH-1:0]      alu_result;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_result;

   modport slave (
      input  req_valid, req_a, req_b, req_op,
      input  alu_result, rsp_ready,
      output req_ready, alu_a, alu_b, alu_op,
      output rsp_valid, rsp_id, rsp_result
   );

   modport master (
      output req_valid, req_a, req_b, req_op,
      output alu_result, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_op,
      input  rsp_valid, rsp_id, rsp_result
   );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or above ptr, wrapping.
// Ports: valid/ptr in; one-hot gnt, index idx and any out. Purely combinational.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);
   int i;

   always_comb begin
      idx = '0;
      any = 1'b0;
      i   = 0;
      for (int k = 0; k < NREQ; k++) begin
         i = (int'(ptr) + k) % NREQ;
         if (!any && valid[i]) begin
            any = 1'b1;
            idx = IDW'(i);
         end
      end
   end

   always_comb begin
      gnt = '0;
      for (int j = 0; j < NREQ; j++)
         gnt[j] = any && (idx == IDW'(j));
   end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU with a one-deep tagged
// response register. Ports: clk, rst_n, bus (alu_arbiter_if.slave).
// Optional ALU_ARB_STATS_EN adds stat_clr in and stat_grants out.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_arbiter_if.slave    bus
`ifdef ALU_ARB_STATS_EN
   ,
   input  logic            stat_clr,
   output logic [NREQ*16-1:0] stat_grants
`endif
);
   localparam int IDW = $clog2(NREQ);

   state_t           state, state_nxt;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] res_q;
   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   g;
   logic             any;
   logic             slot_free;
   logic             accept;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .valid (bus.req_valid),
      .ptr   (rr_ptr),
      .gnt   (gnt),
      .idx   (g),
      .any   (any)
   );

   // rst_n gating keeps req_ready low for the whole reset window
   assign slot_free = (state == EMPTY) | (bus.rsp_ready & (state == FULL));
   assign accept    = any & slot_free & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: if (accept) state_nxt = FULL;
         FULL:  if (!accept && bus.rsp_ready) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      bus.req_ready  = accept ? gnt : '0;
      bus.alu_a      = '0;
      bus.alu_b      = '0;
      bus.alu_op     = '0;
      if (accept) begin
         bus.alu_a  = bus.req_a[int'(g)*WIDTH +: WIDTH];
         bus.alu_b  = bus.req_b[int'(g)*WIDTH +: WIDTH];
         bus.alu_op = bus.req_op[int'(g)*2 +: 2];
      end
      bus.rsp_valid  = (state == FULL);
      bus.rsp_id     = id_q;
      bus.rsp_result = res_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q  <= '0;
         id_q   <= '0;
         rr_ptr <= '0;
      end else if (accept) begin
         res_q  <= bus.alu_result;
         id_q   <= g;
         rr_ptr <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [NREQ*16-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (stat_clr) begin
         cnt <= '0;
      end else begin
         for (int n = 0; n < NREQ; n++)
            if (accept && g == IDW'(n) && cnt[n*16 +: 16] != 16'hFFFF)
               cnt[n*16 +: 16] <= cnt[n*16 +: 16] + 16'd1;
      end
   end

   assign stat_grants = cnt;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NREQ=2, WIDTH=32) with a behavioural
// shared ALU. Stats checks build only with ALU_ARB_STATS_EN.
module tb_alu_arbiter;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   alu_arbiter_if #(.NREQ(2), .WIDTH(32)) bus ();

`ifdef ALU_ARB_STATS_EN
   logic        stat_clr;
   logic [31:0] stat_grants;
`endif

   alu_arbiter #(.NREQ(2), .WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ALU_ARB_STATS_EN
      ,
      .stat_clr    (stat_clr),
      .stat_grants (stat_grants)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // shared ALU: 00 add, 01 or, 10 sub, 11 nand
   always_comb begin
      case (bus.alu_op)
         2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
         2'b01:   bus.alu_result = bus.alu_a | bus.alu_b;
         2'b10:   bus.alu_result = bus.alu_a - bus.alu_b;
         default: bus.alu_result = ~(bus.alu_a & bus.alu_b);
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int id, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] op);
      bus.req_a[id*32 +: 32] = a;
      bus.req_b[id*32 +: 32] = b;
      bus.req_op[id*2 +: 2]  = op;
   endtask

   task automatic do_op(input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp);
      set_req(id, a, b, op);
      bus.req_valid = 2'b01 << id;
      #1;
      chk("op_ready", bus.req_ready, 2'b01 << id);
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
      chk("op_valid", bus.rsp_valid, 1'b1);
      chk("op_id", bus.rsp_id, id);
      chk("op_result", bus.rsp_result, exp);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.req_valid = 2'b11;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_op = '0;
      bus.rsp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      #3;
      chk("rst_ready", bus.req_ready, 2'b00);
      chk("rst_valid", bus.rsp_valid, 1'b0);
      chk("rst_result", bus.rsp_result, 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.req_valid = 2'b00;

      // single requester, 5+3
      @(negedge clk);
      set_req(0, 32'd5, 32'd3, 2'b00);
      bus.req_valid = 2'b01;
      #1;
      chk("t2_ready", bus.req_ready, 2'b01);
      chk("t2_alu_a", bus.alu_a, 32'd5);
      chk("t2_alu_b", bus.alu_b, 32'd3);
      chk("t2_alu_op", bus.alu_op, 2'b00);
      @(negedge clk);
      bus.req_valid = 2'b11;
      #1;
      chk("t2_rsp_valid", bus.rsp_valid, 1'b1);
      chk("t2_rsp_id", bus.rsp_id, 1'b0);
      chk("t2_rsp_result", bus.rsp_result, 32'd8);
      chk("t2_full_ready", bus.req_ready, 2'b00);

      // asynchronous reset while the response register is full
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_valid", bus.rsp_valid, 1'b0);
      chk("t1_id", bus.rsp_id, 1'b0);
      chk("t1_result", bus.rsp_result, 32'd0);
      chk("t1_ready", bus.req_ready, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // alternating grants: req0 1+1, req1 10-4
      set_req(0, 32'd1, 32'd1, 2'b00);
      set_req(1, 32'd10, 32'd4, 2'b10);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("t3_ready", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k > 0) begin
            chk("t3_id", bus.rsp_id, (k - 1) % 2);
            chk("t3_result", bus.rsp_result,
                ((k - 1) % 2 == 0) ? 32'd2 : 32'd6);
         end
      end

      // backpressure for three cycles, then same-cycle drain and refill
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("t4_ready", bus.req_ready, 2'b00);
         chk("t4_valid", bus.rsp_valid, 1'b1);
         chk("t4_id", bus.rsp_id, 1'b1);
         chk("t4_result", bus.rsp_result, 32'd6);
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("t4_refill_ready", bus.req_ready, 2'b01);
      @(negedge clk);
      #1;
      chk("t4_refill_valid", bus.rsp_valid, 1'b1);
      chk("t4_refill_id", bus.rsp_id, 1'b0);
      chk("t4_refill_result", bus.rsp_result, 32'd2);
      bus.req_valid = 2'b00;
      #1;
      chk("idle_ready", bus.req_ready, 2'b00);
      chk("idle_alu_a", bus.alu_a, 32'd0);
      chk("idle_alu_op", bus.alu_op, 2'b00);
      @(negedge clk);
      #1;
      chk("drain_valid", bus.rsp_valid, 1'b0);

      // op coverage
      do_op(0, 32'h0000_00F0, 32'h0000_0F00, 2'b01, 32'h0000_0FF0);
      do_op(1, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 2'b11, 32'hF0F0_F0F0);
      do_op(1, 32'hFFFF_FFFF, 32'h0000_0002, 2'b00, 32'h0000_0001);
      do_op(0, 32'h0000_0000, 32'h0000_0001, 2'b10, 32'hFFFF_FFFF);

      // idle cycles must not move the pointer (last accept was req0)
      repeat (3) @(negedge clk);
      bus.req_valid = 2'b11;
      #1;
      chk("ptr_hold", bus.req_ready, 2'b10);
      @(negedge clk);
      bus.req_valid = 2'b00;

`ifdef ALU_ARB_STATS_EN
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      bus.req_valid = 2'b10;
      repeat (70000) @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      chk("stat_sat1", stat_grants[31:16], 16'hFFFF);
      chk("stat_zero0", stat_grants[15:0], 16'h0000);
      bus.req_valid = 2'b10;
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      bus.req_valid = 2'b00;
      #1;
      chk("stat_clr", stat_grants, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
